// File: rtl/i2c_tx_pkg.sv
// Shared types and defaults for the I2C slave-transmitter controller.
package i2c_tx_pkg;

  localparam int unsigned     DATA_WIDTH_DEF = 8;
  localparam logic [7:0]      IDLE_BYTE_DEF  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    ACK,
    ACKED,
    WAIT_STOP
  } tx_state_t;

endpackage

// File: rtl/i2c_tx_if.sv
// Bus/handshake bundle between the TX timer, transmit buffer and the controller.
interface i2c_tx_if #(
  parameter int unsigned DATA_WIDTH = i2c_tx_pkg::DATA_WIDTH_DEF
) ();

  logic                  rising_edge;
  logic                  falling_edge;
  logic                  start;
  logic                  stop;
  logic                  byte_received;
  logic                  check_ack;
  logic                  ack_done;
  logic                  sda_in;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  sda_out;
  logic                  tx_active;
  logic                  byte_sent;
  logic                  nack_received;
  logic                  underrun;
  logic [7:0]            byte_count;

  modport master (
    output rising_edge, falling_edge, start, stop, byte_received, check_ack,
           ack_done, sda_in, tx_data, tx_valid,
    input  tx_ready, sda_out, tx_active, byte_sent, nack_received, underrun,
           byte_count
  );

  modport slave (
    input  rising_edge, falling_edge, start, stop, byte_received, check_ack,
           ack_done, sda_in, tx_data, tx_valid,
    output tx_ready, sda_out, tx_active, byte_sent, nack_received, underrun,
           byte_count
  );

endinterface

// File: rtl/tx_shift_reg.sv
// MSB-first transmit shift register, fills with 1 so SDA releases after the last bit.
module tx_shift_reg import i2c_tx_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  shift_en,
  input  logic                  clr_cnt,
  output logic                  msb,
  output logic                  next_msb
);

  localparam int unsigned    CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0]  FULL = CW'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;

  // bit_cnt saturates at a full byte; further shifts would only refill 1s anyway
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '1;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= '0;
    end else if (clr_cnt) begin
      bit_cnt <= '0;
    end else if (shift_en && bit_cnt != FULL) begin
      shreg   <= {shreg[DATA_WIDTH-2:0], 1'b1};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign msb      = shreg[DATA_WIDTH-1];
  assign next_msb = shreg[DATA_WIDTH-2];

endmodule

// File: rtl/i2c_tx_controller.sv
// I2C slave-transmitter controller: pulls bytes from the TX buffer, shifts them onto
// SDA MSB-first, samples the master's ACK/NACK and tracks bytes sent since START.
module i2c_tx_controller import i2c_tx_pkg::*; #(
  parameter int unsigned          DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = IDLE_BYTE_DEF
) (
  input  logic clk,
  input  logic rst,
  i2c_tx_if.slave bus
);

  tx_state_t state, state_nxt;

  logic       sda_q, sda_nxt;
  logic       byte_sent_q, byte_sent_nxt;
  logic       nack_q, nack_nxt;
  logic       underrun_q, underrun_nxt;
  logic [7:0] byte_count_q, byte_count_nxt;

  logic                  sr_load, sr_shift, sr_clr;
  logic [DATA_WIDTH-1:0] sr_din;
  logic                  sr_msb, sr_next_msb;

  tx_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .din      (sr_din),
    .shift_en (sr_shift),
    .clr_cnt  (sr_clr),
    .msb      (sr_msb),
    .next_msb (sr_next_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.stop) begin
      state_nxt = IDLE;
    end else if (bus.start) begin
      state_nxt = LOAD;
    end else begin
      case (state)
        IDLE:      state_nxt = IDLE;
        LOAD:      if (bus.tx_valid || bus.rising_edge) state_nxt = SHIFT;
        SHIFT:     if (bus.byte_received) state_nxt = ACK;
        ACK:       if (bus.check_ack) state_nxt = bus.sda_in ? WAIT_STOP : ACKED;
        ACKED:     if (bus.ack_done) state_nxt = LOAD;
        WAIT_STOP: state_nxt = WAIT_STOP;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // sda_out is registered alongside the shift register, so its next value is the
  // MSB the shift register will hold after this edge.
  always_comb begin
    sda_nxt        = 1'b1;
    byte_sent_nxt  = 1'b0;
    nack_nxt       = 1'b0;
    underrun_nxt   = 1'b0;
    byte_count_nxt = byte_count_q;
    sr_load        = 1'b0;
    sr_din         = bus.tx_data;
    sr_shift       = 1'b0;
    sr_clr         = 1'b0;
    if (bus.stop) begin
      sda_nxt = 1'b1;
    end else if (bus.start) begin
      byte_count_nxt = '0;
      sr_clr         = 1'b1;
    end else begin
      case (state)
        LOAD: begin
          if (bus.tx_valid) begin
            sr_load = 1'b1;
            sda_nxt = bus.tx_data[DATA_WIDTH-1];
          end else if (bus.rising_edge) begin
            sr_load      = 1'b1;
            sr_din       = IDLE_BYTE;
            sda_nxt      = IDLE_BYTE[DATA_WIDTH-1];
            underrun_nxt = 1'b1;
          end
        end
        SHIFT: begin
          sr_shift = bus.falling_edge;
          if (bus.byte_received) sda_nxt = 1'b1;
          else if (bus.falling_edge) sda_nxt = sr_next_msb;
          else sda_nxt = sr_msb;
        end
        ACK: begin
          if (bus.check_ack) begin
            byte_sent_nxt  = 1'b1;
            nack_nxt       = bus.sda_in;
            byte_count_nxt = byte_count_q + 8'd1;
          end
        end
        ACKED: if (bus.ack_done) sr_clr = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sda_q        <= 1'b1;
      byte_sent_q  <= 1'b0;
      nack_q       <= 1'b0;
      underrun_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      sda_q        <= sda_nxt;
      byte_sent_q  <= byte_sent_nxt;
      nack_q       <= nack_nxt;
      underrun_q   <= underrun_nxt;
      byte_count_q <= byte_count_nxt;
    end
  end

  assign bus.sda_out       = sda_q;
  assign bus.byte_sent     = byte_sent_q;
  assign bus.nack_received = nack_q;
  assign bus.underrun      = underrun_q;
  assign bus.byte_count    = byte_count_q;
  assign bus.tx_ready      = (state == LOAD);
  assign bus.tx_active     = (state != IDLE);

endmodule

// File: tb/tb_i2c_tx_controller.sv
// Self-checking bench for i2c_tx_controller: directed scenarios plus randomized byte
// streams checked against a bit-level model of the expected SDA and counters.
module tb_i2c_tx_controller;

  logic clk = 1'b0;
  logic rst;

  i2c_tx_if #(.DATA_WIDTH(8)) bus ();

  i2c_tx_controller #(.DATA_WIDTH(8), .IDLE_BYTE(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int model_count = 0;   // bytes completed since last START, modulo 256

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    bus.rising_edge   = 1'b0;
    bus.falling_edge  = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.byte_received = 1'b0;
    bus.check_ack     = 1'b0;
    bus.ack_done      = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    clear_ev();
    model_count = 0;
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL start_ready: got %b want 1", bus.tx_ready);
    end
    checks++;
    if (bus.byte_count !== 8'd0) begin
      errors++; $display("FAIL start_count: got %0d want 0", bus.byte_count);
    end
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick();
    clear_ev();
    checks++;
    if (bus.tx_active !== 1'b0 || bus.sda_out !== 1'b1) begin
      errors++; $display("FAIL stop_idle: got active=%b sda=%b want active=0 sda=1",
                          bus.tx_active, bus.sda_out);
    end
  endtask

  // mode 0: data offered before first SCL rise; 1: buffer empty (underrun);
  // 2: data offered in the same cycle as the first SCL rise
  task automatic do_byte(input logic [7:0] data, input int mode, input bit ack,
                         input bit finish_ack, input bit spurious);
    logic [7:0] exp;
    exp = (mode == 1) ? 8'hFF : data;
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      errors++; $display("FAIL load_ready: got %b want 1", bus.tx_ready);
    end
    if (mode == 1) begin
      bus.tx_valid = 1'b0;
      bus.rising_edge = 1'b1;
    end else begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = data;
      bus.rising_edge = (mode == 2);
    end
    tick();
    clear_ev();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'($urandom);
    checks++;
    if (bus.underrun !== (mode == 1)) begin
      errors++; $display("FAIL underrun_pulse: got %b want %b", bus.underrun, mode == 1);
    end
    checks++;
    if (bus.tx_ready !== 1'b0) begin
      errors++; $display("FAIL ready_drop: got %b want 0", bus.tx_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (i > 0 || mode == 0) begin
        bus.rising_edge = 1'b1;
        tick();
        clear_ev();
      end
      checks++;
      if (bus.sda_out !== exp[7-i]) begin
        errors++; $display("FAIL sda_bit%0d: data %h got %b want %b", i, exp, bus.sda_out, exp[7-i]);
      end
      if (spurious && $urandom_range(0, 1) == 1) begin
        bus.check_ack = 1'b1;
        bus.ack_done  = 1'b1;
        tick();
        clear_ev();
      end
      bus.falling_edge  = 1'b1;
      bus.byte_received = (i == 7);
      tick();
      clear_ev();
    end
    checks++;
    if (bus.sda_out !== 1'b1 || bus.byte_sent !== 1'b0) begin
      errors++; $display("FAIL ack_release: got sda=%b sent=%b want sda=1 sent=0",
                          bus.sda_out, bus.byte_sent);
    end
    bus.sda_in = ack ? 1'b0 : 1'b1;
    bus.rising_edge = 1'b1;
    tick();
    clear_ev();
    bus.check_ack = 1'b1;
    tick();
    clear_ev();
    model_count = (model_count + 1) % 256;
    checks++;
    if (bus.byte_sent !== 1'b1 || bus.nack_received !== !ack) begin
      errors++; $display("FAIL ack_sample: got sent=%b nack=%b want sent=1 nack=%b",
                          bus.byte_sent, bus.nack_received, !ack);
    end
    checks++;
    if (bus.byte_count !== 8'(model_count)) begin
      errors++; $display("FAIL byte_count: got %0d want %0d", bus.byte_count, model_count);
    end
    tick();
    checks++;
    if (bus.byte_sent !== 1'b0 || bus.nack_received !== 1'b0) begin
      errors++; $display("FAIL pulse_width: got sent=%b nack=%b want 0 0",
                          bus.byte_sent, bus.nack_received);
    end
    if (finish_ack || !ack) begin
      bus.falling_edge = 1'b1;
      bus.ack_done     = 1'b1;
      tick();
      clear_ev();
      checks++;
      if (bus.tx_ready !== ack || bus.tx_active !== 1'b1 || bus.sda_out !== 1'b1) begin
        errors++; $display("FAIL after_ack: got ready=%b active=%b sda=%b want ready=%b active=1 sda=1",
                            bus.tx_ready, bus.tx_active, bus.sda_out, ack);
      end
    end
    bus.sda_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.sda_out !== 1'b1 || bus.tx_ready !== 1'b0 || bus.tx_active !== 1'b0 ||
        bus.byte_sent !== 1'b0 || bus.nack_received !== 1'b0 || bus.underrun !== 1'b0 ||
        bus.byte_count !== 8'd0) begin
      errors++; $display("FAIL reset_values: sda=%b rdy=%b act=%b sent=%b nack=%b und=%b cnt=%0d want 1 0 0 0 0 0 0",
                          bus.sda_out, bus.tx_ready, bus.tx_active, bus.byte_sent,
                          bus.nack_received, bus.underrun, bus.byte_count);
    end
  endtask

  task automatic test_basic_byte();
    do_start();
    do_byte(8'hA5, 0, 1'b1, 1'b1, 1'b0);
    do_stop();
  endtask

  task automatic test_two_then_nack();
    do_start();
    do_byte(8'h3C, 0, 1'b1, 1'b1, 1'b0);
    do_byte(8'hC3, 0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      bus.rising_edge = 1'b1; tick(); clear_ev();
      bus.falling_edge = 1'b1; tick(); clear_ev();
    end
    checks++;
    if (bus.sda_out !== 1'b1 || bus.byte_count !== 8'd2 || bus.nack_received !== 1'b0) begin
      errors++; $display("FAIL wait_stop_hold: got sda=%b cnt=%0d nack=%b want 1 2 0",
                          bus.sda_out, bus.byte_count, bus.nack_received);
    end
    do_stop();
  endtask

  task automatic test_underrun();
    do_start();
    do_byte(8'h12, 1, 1'b1, 1'b1, 1'b0);
    do_stop();
  endtask

  task automatic test_coincident_valid();
    do_start();
    do_byte(8'h5A, 2, 1'b1, 1'b1, 1'b0);
    do_stop();
  endtask

  task automatic test_stop_mid_byte();
    do_start();
    bus.tx_valid = 1'b1; bus.tx_data = 8'h00; tick(); bus.tx_valid = 1'b0;
    repeat (3) begin
      bus.rising_edge = 1'b1; tick(); clear_ev();
      bus.falling_edge = 1'b1; tick(); clear_ev();
    end
    checks++;
    if (bus.sda_out !== 1'b0) begin
      errors++; $display("FAIL mid_byte_sda: got %b want 0", bus.sda_out);
    end
    do_stop();
    bus.check_ack = 1'b1; tick(); clear_ev();
    checks++;
    if (bus.byte_sent !== 1'b0 || bus.tx_ready !== 1'b0) begin
      errors++; $display("FAIL stop_no_sent: got sent=%b ready=%b want 0 0",
                          bus.byte_sent, bus.tx_ready);
    end
  endtask

  task automatic test_repeated_start();
    do_start();
    do_byte(8'h81, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.tx_ready !== 1'b0 || bus.tx_active !== 1'b1 || bus.byte_count !== 8'd1) begin
      errors++; $display("FAIL acked_state: got ready=%b active=%b cnt=%0d want 0 1 1",
                          bus.tx_ready, bus.tx_active, bus.byte_count);
    end
    do_start();
    bus.start = 1'b1; bus.stop = 1'b1; tick(); clear_ev();
    checks++;
    if (bus.tx_active !== 1'b0 || bus.sda_out !== 1'b1) begin
      errors++; $display("FAIL start_stop_same: got active=%b sda=%b want 0 1",
                          bus.tx_active, bus.sda_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    do_start();
    do_byte(8'h66, 0, 1'b1, 1'b1, 1'b0);
    bus.tx_valid = 1'b1; bus.tx_data = 8'h00; tick(); bus.tx_valid = 1'b0;
    bus.falling_edge = 1'b1; tick(); clear_ev();
    rst = 1'b1; tick(); rst = 1'b0;
    model_count = 0;
    checks++;
    if (bus.sda_out !== 1'b1 || bus.tx_ready !== 1'b0 || bus.tx_active !== 1'b0 ||
        bus.byte_sent !== 1'b0 || bus.nack_received !== 1'b0 || bus.underrun !== 1'b0 ||
        bus.byte_count !== 8'd0) begin
      errors++; $display("FAIL reset_mid: sda=%b rdy=%b act=%b sent=%b nack=%b und=%b cnt=%0d want 1 0 0 0 0 0 0",
                          bus.sda_out, bus.tx_ready, bus.tx_active, bus.byte_sent,
                          bus.nack_received, bus.underrun, bus.byte_count);
    end
  endtask

  task automatic test_count_wrap();
    do_start();
    for (int n = 0; n < 256; n++) begin
      do_byte(8'($urandom), ($urandom_range(0, 9) == 0) ? 1 : 0, 1'b1, 1'b1,
              $urandom_range(0, 1) == 1);
    end
    checks++;
    if (bus.byte_count !== 8'd0) begin
      errors++; $display("FAIL count_wrap: got %0d want 0", bus.byte_count);
    end
    do_stop();
  endtask

  task automatic test_random_streams();
    for (int t = 0; t < 12; t++) begin
      int len;
      bit nack_last;
      len = $urandom_range(1, 5);
      nack_last = $urandom_range(0, 1) == 1;
      do_start();
      for (int b = 0; b < len; b++) begin
        do_byte(8'($urandom), $urandom_range(0, 2), !(nack_last && b == len - 1), 1'b1,
                $urandom_range(0, 1) == 1);
      end
      checks++;
      if (bus.byte_count !== 8'(len)) begin
        errors++; $display("FAIL stream_count: got %0d want %0d", bus.byte_count, len);
      end
      do_stop();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_ev();
    bus.sda_in   = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    test_reset();
    test_basic_byte();
    test_two_then_nack();
    test_underrun();
    test_coincident_valid();
    test_stop_mid_byte();
    test_repeated_start();
    test_reset_mid_shift();
    test_count_wrap();
    test_random_streams();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
